// File: rtl/dcm_rst_seq.sv
// dcm_rst_seq: two-stage DCM reset sequencer.
// Brings up the first-stage DCM, then the second-stage DCM fed from it, and
// waits for both locks to stay up through a settle window before releasing
// downstream logic. Failed attempts are retried until the budget runs out.
module dcm_rst_seq #(
   parameter int RST_CYCLES    = 16,
   parameter int LOCK_TIMEOUT  = 65535,
   parameter int SETTLE_CYCLES = 1024,
   parameter int MAX_RETRY     = 7
) (
   input  logic       clk48,
   input  logic       rst,
   input  logic       lock_a,
   input  logic       lock_b,
   output logic       dcm_rst_a,
   output logic       dcm_rst_b,
   output logic       user_rst,
   output logic       clk_ok,
   output logic [2:0] retry_cnt,
   output logic       fail
);

   typedef enum logic [2:0] {
      S_RST_A, S_WAIT_A, S_RST_B, S_WAIT_B, S_SETTLE, S_RUN, S_FAIL
   } state_t;

   // Counter runs 0..N-1 inside a state; the last value marks expiry.
   localparam logic [15:0] RST_LAST    = 16'(RST_CYCLES - 1);
   localparam logic [15:0] TO_LAST     = 16'(LOCK_TIMEOUT - 1);
   localparam logic [15:0] SETTLE_LAST = 16'(SETTLE_CYCLES - 1);
   localparam logic [2:0]  RETRY_LAST  = 3'(MAX_RETRY - 1);

   state_t      state, next_state;
   logic [15:0] cnt;
   logic        lock_a_q1, lock_a_s, lock_b_q1, lock_b_s;
   logic        attempt_fail;
   logic        both_lock;

   logic        dcm_rst_a_nxt, dcm_rst_b_nxt, user_rst_nxt, clk_ok_nxt, fail_nxt;
   logic [2:0]  retry_nxt;

   assign both_lock = lock_a_s & lock_b_s;

   // Two-flop synchronizers for the asynchronous lock inputs.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         lock_a_q1 <= 1'b0;
         lock_a_s  <= 1'b0;
         lock_b_q1 <= 1'b0;
         lock_b_s  <= 1'b0;
      end else begin
         lock_a_q1 <= lock_a;
         lock_a_s  <= lock_a_q1;
         lock_b_q1 <= lock_b;
         lock_b_s  <= lock_b_q1;
      end
   end

   // State register.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) state <= S_RST_A;
      else     state <= next_state;
   end

   // Next-state logic; a lock seen on an expiry cycle takes precedence.
   always_comb begin
      next_state   = state;
      attempt_fail = 1'b0;
      case (state)
         S_RST_A:  if (cnt == RST_LAST) next_state = S_WAIT_A;
         S_WAIT_A: begin
            if (lock_a_s)             next_state = S_RST_B;
            else if (cnt == TO_LAST)  attempt_fail = 1'b1;
         end
         S_RST_B: begin
            if (!lock_a_s)            attempt_fail = 1'b1;
            else if (cnt == RST_LAST) next_state = S_WAIT_B;
         end
         S_WAIT_B: begin
            if (!lock_a_s)            attempt_fail = 1'b1;
            else if (lock_b_s)        next_state = S_SETTLE;
            else if (cnt == TO_LAST)  attempt_fail = 1'b1;
         end
         S_SETTLE: begin
            if (!both_lock)              attempt_fail = 1'b1;
            else if (cnt == SETTLE_LAST) next_state = S_RUN;
         end
         S_RUN:    if (!both_lock) next_state = S_RST_A;
         S_FAIL:   next_state = S_FAIL;
         default:  next_state = S_RST_A;
      endcase
      if (attempt_fail)
         next_state = (retry_cnt == RETRY_LAST) ? S_FAIL : S_RST_A;
   end

   // Output decode from the next state so the output flops track the state flop.
   always_comb begin
      dcm_rst_a_nxt = 1'b1;
      dcm_rst_b_nxt = 1'b1;
      user_rst_nxt  = 1'b1;
      clk_ok_nxt    = 1'b0;
      fail_nxt      = 1'b0;
      retry_nxt     = retry_cnt;
      case (next_state)
         S_WAIT_A, S_RST_B: dcm_rst_a_nxt = 1'b0;
         S_WAIT_B, S_SETTLE: begin
            dcm_rst_a_nxt = 1'b0;
            dcm_rst_b_nxt = 1'b0;
         end
         S_RUN: begin
            dcm_rst_a_nxt = 1'b0;
            dcm_rst_b_nxt = 1'b0;
            user_rst_nxt  = 1'b0;
            clk_ok_nxt    = 1'b1;
         end
         S_FAIL:  fail_nxt = 1'b1;
         default: ;
      endcase
      if (attempt_fail && retry_cnt != 3'd7)
         retry_nxt = retry_cnt + 3'd1;
      if (next_state == S_RUN)
         retry_nxt = 3'd0;
   end

   // Registered outputs.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst) begin
         dcm_rst_a <= 1'b1;
         dcm_rst_b <= 1'b1;
         user_rst  <= 1'b1;
         clk_ok    <= 1'b0;
         fail      <= 1'b0;
         retry_cnt <= 3'd0;
      end else begin
         dcm_rst_a <= dcm_rst_a_nxt;
         dcm_rst_b <= dcm_rst_b_nxt;
         user_rst  <= user_rst_nxt;
         clk_ok    <= clk_ok_nxt;
         fail      <= fail_nxt;
         retry_cnt <= retry_nxt;
      end
   end

   // Shared interval counter: cleared on every state entry, idle in RUN/FAIL.
   always_ff @(posedge clk48 or posedge rst) begin
      if (rst)                             cnt <= '0;
      else if (next_state != state)        cnt <= '0;
      else if (state inside {S_RUN, S_FAIL}) cnt <= cnt;
      else                                 cnt <= cnt + 16'd1;
   end

endmodule
